// File: rtl/muldiv_defs_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: FSM states,
// op encoding {op_div, op_signed} and the divide-by-zero quotient.
package muldiv_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_t;

   localparam int unsigned MAX_WIDTH = 64;
   localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/muldiv_iter_core.sv
// Per-cycle mul/div datapath: restoring-divide or shift-add step on magnitudes.
// MULDIV_FAST_MULT_EN replaces the multiply step with a full combinational product.
module muldiv_iter_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic             step,
   input  logic             op_div,
   input  logic [WIDTH-1:0] init_lo,
   input  logic [WIDTH-1:0] init_opnd,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd;
   logic             mode_div;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
`ifndef MULDIV_FAST_MULT_EN
   logic [WIDTH:0]   sum;
`endif

   always_comb begin
      trial  = {acc_hi, acc_lo[WIDTH-1]};
      diff   = trial - {1'b0, opnd};
      nxt_hi = '0;
      nxt_lo = '0;
`ifndef MULDIV_FAST_MULT_EN
      sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
`endif
      if (mode_div) begin
         // borrow out of the W+1-bit trial subtraction means "does not fit"
         if (!diff[WIDTH]) begin
            nxt_hi = diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = trial[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
`ifdef MULDIV_FAST_MULT_EN
         {nxt_hi, nxt_lo} = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc_lo};
`else
         {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:1]};
`endif
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         mode_div <= 1'b0;
      end else if (load) begin
         acc_hi   <= '0;
         acc_lo   <= init_lo;
         opnd     <= init_opnd;
         mode_div <= op_div;
      end else if (step) begin
         acc_hi   <= nxt_hi;
         acc_lo   <= nxt_lo;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit: FSM, counter, sign handling, stall/done.
// MULDIV_FAST_MULT_EN selects a single-cycle multiply; divide is always iterative.
module ex_muldiv
   import muldiv_defs::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             op_div,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               div_r;
   logic               neg_q;
   logic               neg_r;
   logic               div0_r;

   op_t                op;
   logic               is_signed;
   logic               accept;
   logic               finish;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   nxt_hi;
   logic [WIDTH-1:0]   nxt_lo;
   logic [WIDTH-1:0]   fin_q;
   logic [WIDTH-1:0]   fin_r;
   logic [2*WIDTH-1:0] fin_p;

   assign op        = op_t'({op_div, op_signed});
   assign is_signed = (op == OP_MULT) || (op == OP_DIV);
   assign accept    = start && !cancel && (state != ST_CALC);
   assign mag_a     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
   assign mag_b     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

   assign busy  = (state != ST_IDLE);
   assign done  = (state == ST_DONE);
   assign stall = ((state == ST_IDLE) && start && !cancel) || (state == ST_CALC);

`ifdef MULDIV_FAST_MULT_EN
   assign finish = div_r ? (cnt == CNT_W'(WIDTH - 1)) : 1'b1;
`else
   assign finish = (cnt == CNT_W'(WIDTH - 1));
`endif

   muldiv_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk       (clk),
      .resetn    (resetn),
      .load      (accept),
      .step      (state == ST_CALC),
      .op_div    (op_div),
      .init_lo   (op_div ? mag_a : mag_b),
      .init_opnd (op_div ? mag_b : mag_a),
      .nxt_hi    (nxt_hi),
      .nxt_lo    (nxt_lo)
   );

   assign fin_q = neg_q ? -nxt_lo : nxt_lo;
   assign fin_r = neg_r ? -nxt_hi : nxt_hi;
   assign fin_p = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};

   // Sign-fixed result is captured on the edge into DONE so it is valid alongside done.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         div_r  <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0_r <= 1'b0;
         res_hi <= '0;
         res_lo <= '0;
      end else begin
         if (accept) begin
            cnt    <= '0;
            div_r  <= op_div;
            neg_q  <= is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r  <= is_signed && src_a[WIDTH-1];
            div0_r <= op_div && (src_b == '0);
         end
         case (state)
            ST_IDLE: begin
               if (accept) state <= ST_CALC;
            end
            ST_CALC: begin
               if (cancel) begin
                  state <= ST_IDLE;
               end else if (finish) begin
                  state <= ST_DONE;
                  if (div_r) begin
                     res_hi <= fin_r;
                     res_lo <= div0_r ? DIV0_QUOTIENT[WIDTH-1:0] : fin_q;
                  end else begin
                     {res_hi, res_lo} <= fin_p;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= accept ? ST_CALC : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
